// File: rtl/usb_cmd_pkg.sv
// Shared frame constants, command codes and parser state for the USB-CDC
// command path.
package usb_cmd_pkg;

  localparam logic [7:0] SOF1 = 8'hAA;
  localparam logic [7:0] SOF2 = 8'h55;

  localparam logic [7:0] CMD_SPI  = 8'h11;
  localparam logic [7:0] CMD_UART = 8'h12;
  localparam logic [7:0] CMD_PWM  = 8'h13;
  localparam logic [7:0] CMD_DAC  = 8'h14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR2,
    S_CMD,
    S_LEN_H,
    S_LEN_L,
    S_PAYLOAD,
    S_CHK
  } state_t;

  function automatic logic [7:0] csum_add(
    input logic [7:0] acc,
    input logic [7:0] b
  );
    return acc + b;
  endfunction

endpackage

// File: rtl/usb_cmd_timeout.sv
// Inter-byte timeout counter: clears on clr, counts while en, pulses
// expire combinationally on the cycle whose edge would reach the limit.
module usb_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 60000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = en && !clr && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= expire ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/usb_cmd_parser.sv
// Frame parser: AA 55 CMD LEN_H LEN_L PAYLOAD CHK -> header/data/done/error
// pulses. Optional inter-byte timeout under USB_CMD_PARSER_TIMEOUT_EN.
import usb_cmd_pkg::*;

module usb_cmd_parser #(
  parameter int unsigned MAX_PAYLOAD    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  usb_data_in,
  input  logic        usb_data_valid_in,
  output logic        cmd_start,
  output logic [7:0]  cmd_type,
  output logic [15:0] cmd_length,
  output logic [7:0]  cmd_data,
  output logic [15:0] cmd_data_index,
  output logic        cmd_data_valid,
  output logic        cmd_done,
  output logic        cmd_error
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  state_t      state, state_nx;
  logic [7:0]  sum, sum_nx;
  logic [7:0]  typ_q, typ_nx;
  logic [7:0]  len_h, len_h_nx;
  logic [15:0] cnt, cnt_nx;
  logic [15:0] frame_len;

  logic        start_nx, dv_nx, done_nx, err_nx;
  logic [7:0]  type_nx, data_nx;
  logic [15:0] length_nx, index_nx;
  logic        tmo_expire;

`ifdef USB_CMD_PARSER_TIMEOUT_EN
  usb_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (usb_data_valid_in),
    .en    (state != S_IDLE),
    .expire(tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  assign frame_len = {len_h, usb_data_in};

  always_comb begin
    state_nx  = state;
    sum_nx    = sum;
    typ_nx    = typ_q;
    len_h_nx  = len_h;
    cnt_nx    = cnt;
    start_nx  = 1'b0;
    dv_nx     = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    type_nx   = cmd_type;
    length_nx = cmd_length;
    data_nx   = cmd_data;
    index_nx  = cmd_data_index;

    if (usb_data_valid_in) begin
      unique case (state)
        S_IDLE: begin
          if (usb_data_in == SOF1) state_nx = S_HDR2;
        end
        S_HDR2: begin
          unique case (1'b1)
            (usb_data_in == SOF2): begin
              state_nx = S_CMD;
              sum_nx   = '0;
            end
            (usb_data_in == SOF1): state_nx = S_HDR2;
            default:               state_nx = S_IDLE;
          endcase
        end
        S_CMD: begin
          typ_nx   = usb_data_in;
          sum_nx   = csum_add(sum, usb_data_in);
          state_nx = S_LEN_H;
        end
        S_LEN_H: begin
          len_h_nx = usb_data_in;
          sum_nx   = csum_add(sum, usb_data_in);
          state_nx = S_LEN_L;
        end
        S_LEN_L: begin
          sum_nx = csum_add(sum, usb_data_in);
          if (frame_len > MAX_LEN) begin
            err_nx   = 1'b1;
            state_nx = S_IDLE;
          end else begin
            start_nx  = 1'b1;
            type_nx   = typ_q;
            length_nx = frame_len;
            cnt_nx    = '0;
            state_nx  = (frame_len == '0) ? S_CHK : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          dv_nx    = 1'b1;
          data_nx  = usb_data_in;
          index_nx = cnt;
          cnt_nx   = cnt + 16'd1;
          sum_nx   = csum_add(sum, usb_data_in);
          if (cnt == cmd_length - 16'd1) state_nx = S_CHK;
        end
        S_CHK: begin
          done_nx  = (usb_data_in == sum);
          err_nx   = (usb_data_in != sum);
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end else if (tmo_expire) begin
      err_nx   = 1'b1;
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      sum            <= '0;
      typ_q          <= '0;
      len_h          <= '0;
      cnt            <= '0;
      cmd_start      <= 1'b0;
      cmd_type       <= '0;
      cmd_length     <= '0;
      cmd_data       <= '0;
      cmd_data_index <= '0;
      cmd_data_valid <= 1'b0;
      cmd_done       <= 1'b0;
      cmd_error      <= 1'b0;
    end else begin
      state          <= state_nx;
      sum            <= sum_nx;
      typ_q          <= typ_nx;
      len_h          <= len_h_nx;
      cnt            <= cnt_nx;
      cmd_start      <= start_nx;
      cmd_type       <= type_nx;
      cmd_length     <= length_nx;
      cmd_data       <= data_nx;
      cmd_data_index <= index_nx;
      cmd_data_valid <= dv_nx;
      cmd_done       <= done_nx;
      cmd_error      <= err_nx;
    end
  end

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Directed bench for usb_cmd_parser with an event scoreboard.
// Timeout steps are active when USB_CMD_PARSER_TIMEOUT_EN is defined.
import usb_cmd_pkg::*;

module tb_usb_cmd_parser;

  localparam int EV_START = 0;
  localparam int EV_DATA  = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERR   = 3;

  typedef struct {
    int          kind;
    logic [7:0]  v8;
    logic [15:0] v16;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        vld;
  logic        cmd_start;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_length;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_data_index;
  logic        cmd_data_valid;
  logic        cmd_done;
  logic        cmd_error;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  usb_cmd_parser #(
    .MAX_PAYLOAD   (256),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .usb_data_in      (din),
    .usb_data_valid_in(vld),
    .cmd_start        (cmd_start),
    .cmd_type         (cmd_type),
    .cmd_length       (cmd_length),
    .cmd_data         (cmd_data),
    .cmd_data_index   (cmd_data_index),
    .cmd_data_valid   (cmd_data_valid),
    .cmd_done         (cmd_done),
    .cmd_error        (cmd_error)
  );

  task automatic push(input int k, input logic [7:0] a, input logic [15:0] b);
    ev_t e;
    e.kind = k;
    e.v8   = a;
    e.v16  = b;
    sb.push_back(e);
  endtask

  task automatic chk_ev(input int k, input logic [7:0] a, input logic [15:0] b);
    ev_t e;
    n_tests++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL unexpected_pulse kind=%0d v8=%h v16=%0d, none expected", k, a, b);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      assert (k === e.kind && a === e.v8 && b === e.v16) else begin
        n_fail++;
        $error("FAIL event got kind=%0d v8=%h v16=%0d expected kind=%0d v8=%h v16=%0d",
               k, a, b, e.kind, e.v8, e.v16);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_start)      chk_ev(EV_START, cmd_type, cmd_length);
      if (cmd_data_valid) chk_ev(EV_DATA, cmd_data, cmd_data_index);
      if (cmd_done)       chk_ev(EV_DONE, 8'h00, 16'h0000);
      if (cmd_error)      chk_ev(EV_ERR, 8'h00, 16'h0000);
      if (cmd_start || cmd_data_valid || cmd_done || cmd_error) begin
        n_tests++;
        assert ((int'(cmd_start) + int'(cmd_data_valid) + int'(cmd_done)
                 + int'(cmd_error)) <= 1) else begin
          n_fail++;
          $error("FAIL pulse_overlap got start=%b dv=%b done=%b err=%b expected one",
                 cmd_start, cmd_data_valid, cmd_done, cmd_error);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    din = b;
    vld = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  // Generated frame: payload bytes derived from seed, checksum from the bench.
  task automatic frame(input logic [7:0] t, input int len,
                       input logic [7:0] seed, input bit bad);
    logic [15:0] l;
    logic [7:0]  s;
    logic [7:0]  d;
    l = 16'(len);
    s = t + l[15:8] + l[7:0];
    send(SOF1);
    send(SOF2);
    send(t);
    send(l[15:8]);
    push(EV_START, t, l);
    send(l[7:0]);
    for (int i = 0; i < len; i++) begin
      d = 8'(int'(seed) + i * 37);
      push(EV_DATA, d, 16'(i));
      send(d);
      s = s + d;
    end
    if (bad) push(EV_ERR, 8'h00, 16'h0000);
    else     push(EV_DONE, 8'h00, 16'h0000);
    send(bad ? s + 8'h01 : s);
  endtask

  task automatic check_quiet(input string tag);
    n_tests++;
    assert (cmd_start === 1'b0 && cmd_data_valid === 1'b0 && cmd_done === 1'b0
            && cmd_error === 1'b0 && cmd_type === 8'h00 && cmd_length === 16'h0
            && cmd_data === 8'h00 && cmd_data_index === 16'h0) else begin
      n_fail++;
      $error("FAIL %s got st=%b dv=%b dn=%b er=%b ty=%h len=%0d d=%h idx=%0d expected all 0",
             tag, cmd_start, cmd_data_valid, cmd_done, cmd_error, cmd_type,
             cmd_length, cmd_data, cmd_data_index);
    end
    n_tests++;
    assert (dut.state === S_IDLE) else begin
      n_fail++;
      $error("FAIL %s_state got %0d expected %0d", tag, dut.state, S_IDLE);
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    vld = 1'b0;
    din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("reset");

    // good frame
    push(EV_START, 8'h11, 16'd3);
    push(EV_DATA, 8'h01, 16'd0);
    push(EV_DATA, 8'h01, 16'd1);
    push(EV_DATA, 8'hDE, 16'd2);
    push(EV_DONE, 8'h00, 16'h0);
    send_list('{8'hAA, 8'h55, 8'h11, 8'h00, 8'h03, 8'h01, 8'h01, 8'hDE, 8'hF4});
    idle(2);

    // bad checksum
    push(EV_START, 8'h11, 16'd3);
    push(EV_DATA, 8'h01, 16'd0);
    push(EV_DATA, 8'h01, 16'd1);
    push(EV_DATA, 8'hDE, 16'd2);
    push(EV_ERR, 8'h00, 16'h0);
    send_list('{8'hAA, 8'h55, 8'h11, 8'h00, 8'h03, 8'h01, 8'h01, 8'hDE, 8'hF5});
    idle(2);

    // zero payload
    push(EV_START, 8'h11, 16'd0);
    push(EV_DONE, 8'h00, 16'h0);
    send_list('{8'hAA, 8'h55, 8'h11, 8'h00, 8'h00, 8'h11});
    idle(2);

    // junk, repeated SOF1, then oversize length straight after
    push(EV_START, 8'h11, 16'd0);
    push(EV_DONE, 8'h00, 16'h0);
    push(EV_ERR, 8'h00, 16'h0);
    send_list('{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h11, 8'h00, 8'h00, 8'h11,
                8'hAA, 8'h55, 8'h11, 8'h01, 8'h01});
    idle(2);

    // broken header drops back to IDLE silently
    send_list('{8'hAA, 8'h12, 8'h55, 8'h11});
    idle(2);
    n_tests++;
    assert (dut.state === S_IDLE) else begin
      n_fail++;
      $error("FAIL hdr_abort_state got %0d expected %0d", dut.state, S_IDLE);
    end

    // back-to-back frames, max length, other command codes
    frame(CMD_UART, 5, 8'h3C, 1'b0);
    frame(CMD_PWM, 256, 8'h07, 1'b0);
    frame(CMD_DAC, 1, 8'hFF, 1'b1);
    frame(CMD_SPI, 2, 8'h80, 1'b0);
    idle(3);

`ifdef USB_CMD_PARSER_TIMEOUT_EN
    // stalled frame times out 100 cycles after its last byte
    push(EV_START, 8'h11, 16'd2);
    push(EV_DATA, 8'h01, 16'd0);
    send_list('{8'hAA, 8'h55, 8'h11, 8'h00, 8'h02, 8'h01});
    push(EV_ERR, 8'h00, 16'h0);
    vld = 1'b0;
    cyc = 0;
    while (cyc < 300 && cmd_error !== 1'b1) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_tests++;
    assert (cyc === 100) else begin
      n_fail++;
      $error("FAIL timeout_latency got %0d cycles expected 100", cyc);
    end
    idle(2);
    frame(CMD_SPI, 3, 8'h21, 1'b0);
    idle(2);
`else
    // without timeout a stalled frame simply resumes
    push(EV_START, 8'h11, 16'd2);
    push(EV_DATA, 8'h01, 16'd0);
    send_list('{8'hAA, 8'h55, 8'h11, 8'h00, 8'h02, 8'h01});
    idle(150);
    n_tests++;
    assert (dut.state === S_PAYLOAD) else begin
      n_fail++;
      $error("FAIL stall_state got %0d expected %0d", dut.state, S_PAYLOAD);
    end
    push(EV_DATA, 8'h02, 16'd1);
    push(EV_DONE, 8'h00, 16'h0);
    send_list('{8'h02, 8'h16});
    idle(2);
`endif

    // reset mid-payload abandons the frame silently
    push(EV_START, 8'h11, 16'd3);
    push(EV_DATA, 8'h01, 16'd0);
    send_list('{8'hAA, 8'h55, 8'h11, 8'h00, 8'h03, 8'h01});
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("mid_reset");
    push(EV_START, 8'h11, 16'd3);
    push(EV_DATA, 8'h01, 16'd0);
    push(EV_DATA, 8'h01, 16'd1);
    push(EV_DATA, 8'hDE, 16'd2);
    push(EV_DONE, 8'h00, 16'h0);
    send_list('{8'hAA, 8'h55, 8'h11, 8'h00, 8'h03, 8'h01, 8'h01, 8'hDE, 8'hF4});
    idle(5);

    n_tests++;
    assert (sb.size() === 0) else begin
      n_fail++;
      $error("FAIL drain got %0d pending events expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
